// File: rtl/bht_pkg.sv
// Shared types and helpers for the single-port BHT scheduler: entry layout,
// 2-bit counter encodings and the saturating counter step.
package bht_pkg;

    // Widest tag any supported geometry needs (ENTRY_NUM = 1); narrower tags are zero-extended.
    localparam int BHT_MAX_TAG_BITS   = 30;
    localparam int BHT_MAX_ENTRY_BITS = BHT_MAX_TAG_BITS + 3;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } bht_counter_t;

    typedef struct packed {
        logic                        valid;
        logic [BHT_MAX_TAG_BITS-1:0] tag;
        logic [1:0]                  counter;
    } bht_entry_t;

    function automatic logic [1:0] bht_next_counter(input logic [1:0] counter, input logic taken);
        logic [1:0] result;
        result = counter;
        if (taken) begin
            if (counter != CNT_ST) result = counter + 2'd1;
        end else if (counter != CNT_SNT) begin
            result = counter - 2'd1;
        end
        return result;
    endfunction

    // Packs an entry as {valid, tag[tag_bits-1:0], counter} in the low bits of the result.
    function automatic logic [BHT_MAX_ENTRY_BITS-1:0] bht_flatten(input bht_entry_t entry, input int tag_bits);
        logic [BHT_MAX_TAG_BITS-1:0]   tag_mask;
        logic [BHT_MAX_ENTRY_BITS-1:0] bits;
        tag_mask = (BHT_MAX_TAG_BITS'(1) << tag_bits) - BHT_MAX_TAG_BITS'(1);
        bits     = BHT_MAX_ENTRY_BITS'(entry.counter);
        bits     = bits | (BHT_MAX_ENTRY_BITS'(entry.tag & tag_mask) << 2);
        bits     = bits | (BHT_MAX_ENTRY_BITS'(entry.valid) << (tag_bits + 2));
        return bits;
    endfunction

endpackage

// File: rtl/bht_update_queue.sv
// Circular FIFO of pending BHT writes (index + next entry) with a head port.
// With BHT_SCHED_BYPASS_EN defined it also offers a youngest-match index search.
module bht_update_queue
    import bht_pkg::*;
#(
    parameter int QDEPTH     = 4,
    parameter int INDEX_BITS = 13
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [INDEX_BITS-1:0]   push_index,
    input  bht_entry_t              push_entry,
    input  logic                    pop,
    output logic [INDEX_BITS-1:0]   head_index,
    output bht_entry_t              head_entry,
    output logic [$clog2(QDEPTH):0] count
`ifdef BHT_SCHED_BYPASS_EN
    ,
    input  logic [INDEX_BITS-1:0]   search_index,
    output logic                    search_hit,
    output bht_entry_t              search_entry
`endif
);

    localparam int PTR_BITS = $clog2(QDEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [INDEX_BITS-1:0] index_mem [QDEPTH];
    bht_entry_t            entry_mem [QDEPTH];
    logic [PTR_BITS-1:0]   rd_ptr_reg;
    logic [PTR_BITS-1:0]   wr_ptr_reg;
    logic [CNT_BITS-1:0]   count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            index_mem[wr_ptr_reg] <= push_index;
            entry_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
            if (push && !pop)      count_reg <= count_reg + CNT_BITS'(1);
            else if (pop && !push) count_reg <= count_reg - CNT_BITS'(1);
        end
    end

    assign head_index = index_mem[rd_ptr_reg];
    assign head_entry = entry_mem[rd_ptr_reg];
    assign count      = count_reg;

`ifdef BHT_SCHED_BYPASS_EN
    logic [QDEPTH-1:0] match;
    bht_entry_t        slot_entry [QDEPTH];

    // Slot gi holds the entry at age offset gi from the head; larger offset = younger.
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_search
        logic [PTR_BITS-1:0] slot;
        assign slot           = rd_ptr_reg + PTR_BITS'(gi);
        assign match[gi]      = (CNT_BITS'(gi) < count_reg) && (index_mem[slot] == search_index);
        assign slot_entry[gi] = entry_mem[slot];
    end

    always_comb begin
        search_hit   = 1'b0;
        search_entry = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            if (match[k]) begin
                search_hit   = 1'b1;
                search_entry = slot_entry[k];
            end
        end
    end
`endif

endmodule

// File: rtl/bht_port_scheduler.sv
// Arbitrates a 1RW BHT SRAM between fetch lookups, queued EX updates and the post-reset clear.
// Define BHT_SCHED_BYPASS_EN to let lookups see not-yet-written queued updates.
module bht_port_scheduler
    import bht_pkg::*;
#(
    parameter int ENTRY_NUM    = 8192,
    parameter int INDEX_BITS   = $clog2(ENTRY_NUM),
    parameter int TAG_BITS     = 32 - (INDEX_BITS + 2),
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lu_valid,
    input  logic [INDEX_BITS-1:0] lu_index,
    input  logic [TAG_BITS-1:0]   lu_tag,
    output logic                  lu_ready,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic                  rsp_taken,
    output logic [1:0]            rsp_counter,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [INDEX_BITS-1:0] up_index,
    input  logic [TAG_BITS-1:0]   up_tag,
    input  logic                  up_taken,
    input  logic                  up_old_hit,
    input  logic [1:0]            up_old_counter,
    output logic                  arr_en,
    output logic                  arr_we,
    output logic [INDEX_BITS-1:0] arr_addr,
    output logic [TAG_BITS+2:0]   arr_wdata,
    input  logic [TAG_BITS+2:0]   arr_rdata,
    output logic                  init_done
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int STARVE_BITS = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_BITS    = $clog2(QDEPTH) + 1;
    localparam logic [INDEX_BITS-1:0]  LAST_INDEX = INDEX_BITS'(ENTRY_NUM - 1);
    localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(STARVE_LIMIT);
    localparam logic [CNT_BITS-1:0]    Q_FULL     = CNT_BITS'(QDEPTH);

    logic [0:0]             state_reg;
    logic [INDEX_BITS-1:0]  sweep_reg;
    logic [STARVE_BITS-1:0] starve_reg;
    logic                   rsp_valid_reg;
    logic [TAG_BITS-1:0]    lu_tag_reg;

    logic [CNT_BITS-1:0]    q_count;
    logic [INDEX_BITS-1:0]  q_head_index;
    bht_entry_t             q_head_entry;
    bht_entry_t             push_entry;
    logic in_init, in_run, q_nonempty, force_write, lu_fire, do_write, push;
    logic [TAG_BITS+2:0]    rd_bits;

    // Reset gates every access so a pending write cannot slip out while reset is held.
    assign in_init     = (state_reg == ST_INIT) && !reset;
    assign in_run      = (state_reg == ST_RUN) && !reset;
    assign q_nonempty  = (q_count != '0);
    assign force_write = (q_count == Q_FULL) || (q_nonempty && starve_reg == STARVE_MAX);
    assign lu_ready    = in_run && !force_write;
    assign lu_fire     = lu_valid && lu_ready;
    assign do_write    = in_run && q_nonempty && !lu_fire;
    assign up_ready    = in_run && (q_count < Q_FULL);
    assign push        = up_valid && up_ready;
    assign init_done   = (state_reg == ST_RUN);

    always_comb begin
        push_entry       = '0;
        push_entry.valid = 1'b1;
        push_entry.tag   = BHT_MAX_TAG_BITS'(up_tag);
        if (!up_old_hit) push_entry.counter = up_taken ? CNT_WT : CNT_WNT;
        else             push_entry.counter = bht_next_counter(up_old_counter, up_taken);
    end

`ifdef BHT_SCHED_BYPASS_EN
    logic       search_hit;
    bht_entry_t search_entry;
    logic       byp_hit_reg;
    bht_entry_t byp_entry_reg;
`endif

    bht_update_queue #(
        .QDEPTH     (QDEPTH),
        .INDEX_BITS (INDEX_BITS)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_index   (up_index),
        .push_entry   (push_entry),
        .pop          (do_write),
        .head_index   (q_head_index),
        .head_entry   (q_head_entry),
        .count        (q_count)
`ifdef BHT_SCHED_BYPASS_EN
        ,
        .search_index (lu_index),
        .search_hit   (search_hit),
        .search_entry (search_entry)
`endif
    );

    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = lu_index;
        arr_wdata = '0;
        if (in_init) begin
            arr_en    = 1'b1;
            arr_we    = 1'b1;
            arr_addr  = sweep_reg;
            arr_wdata = {1'b0, {TAG_BITS{1'b0}}, CNT_WNT};
        end else if (do_write) begin
            arr_en    = 1'b1;
            arr_we    = 1'b1;
            arr_addr  = q_head_index;
            arr_wdata = (TAG_BITS + 3)'(bht_flatten(q_head_entry, TAG_BITS));
        end else if (lu_fire) begin
            arr_en    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            sweep_reg     <= '0;
            starve_reg    <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            if (in_init) begin
                sweep_reg <= sweep_reg + INDEX_BITS'(1);
                if (sweep_reg == LAST_INDEX) state_reg <= ST_RUN;
            end
            if (do_write || !q_nonempty) starve_reg <= '0;
            else if (lu_fire)            starve_reg <= starve_reg + STARVE_BITS'(1);
            rsp_valid_reg <= lu_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (lu_fire) begin
            lu_tag_reg <= lu_tag;
`ifdef BHT_SCHED_BYPASS_EN
            byp_hit_reg   <= search_hit;
            byp_entry_reg <= search_entry;
`endif
        end
    end

    always_comb begin
        rd_bits = arr_rdata;
`ifdef BHT_SCHED_BYPASS_EN
        if (byp_hit_reg) rd_bits = (TAG_BITS + 3)'(bht_flatten(byp_entry_reg, TAG_BITS));
`endif
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_hit     = rsp_valid_reg && rd_bits[TAG_BITS+2] && (rd_bits[TAG_BITS+1:2] == lu_tag_reg);
    assign rsp_counter = rsp_hit ? rd_bits[1:0] : CNT_WNT;
    assign rsp_taken   = rsp_hit && rd_bits[1];

endmodule
